minmax_tracker: RTL and testbench
=================================

# minmax_tracker

Streaming unsigned min/max tracker, directly downstream of the N-bit magnitude comparator. It accepts a packet of N-bit samples over a valid/ready handshake and uses two comparator instances, one per running extreme, to update a running maximum and minimum. When the last sample of the packet is accepted, it presents the maximum, minimum and sample count on a held output handshake. It is the first sequential consumer of the comparator's g/l flags in the datapath.

## Interface
- N, default 4: sample width in bits; also the width of both comparator instances.
- CW, default 8: width of the sample counter.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  in_data/in_last are valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  N  unsigned sample.
- in_last  in  1  marks the final sample of a packet.
- out_valid  out  1  out_max/out_min/out_count are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- out_max  out  N  largest sample of the packet.
- out_min  out  N  smallest sample of the packet.
- out_count  out  CW  number of samples in the packet, saturating.

## Operation
- Comparator contract: g=1 iff A>B, l=1 iff A<B, both 0 iff A==B; unsigned.
- Instance X: A=in_data, B=max_r; its g triggers a max update.
- Instance Y: A=in_data, B=min_r; its l triggers a min update.
- Equal values never update a register (ties keep the stored value).
- An input beat is accepted when in_valid && in_ready.
- FSM states: FIRST, ACC, DONE. Reset enters FIRST.
- FIRST: in_ready=1. On an accepted beat: max_r=min_r=in_data, cnt=1. If in_last=1, go to DONE; otherwise go to ACC. Comparator outputs are ignored in this state.
- ACC: in_ready=1. On an accepted beat: max_r=in_data if X.g, min_r=in_data if Y.l, cnt=cnt+1 saturating at 2^CW-1. If in_last=1, go to DONE; otherwise stay in ACC.
- ACC with no accepted beat: all state holds; gaps in in_valid are allowed.
- DONE: in_ready=0 and out_valid=1. out_max/out_min/out_count are driven from the registers and stay stable until the output handshake. When out_ready=1, go to FIRST on the next cycle.
- in_data, in_valid and in_last are don't-care in DONE; no beat is accepted there.
- Counter saturation does not affect max/min tracking; samples are still compared.
- Combinational paths: in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.

## Timing
- Reset values: out_valid=0, out_max=0, out_min=0, out_count=0, state FIRST, and therefore in_ready=1 in the first cycle after reset.
- rst has priority over every other input; asserting it in any state, including mid-packet or DONE with out_valid high, discards the packet and applies the reset values on the next edge.
- Latency: a beat with in_last accepted at edge k gives out_valid=1 in the cycle after edge k.
- Earliest next packet: if out_ready=1 in the first DONE cycle, DONE lasts one cycle and in_ready=1 again one cycle later. Minimum packet-to-packet spacing is one bubble cycle.
- Backpressure: out_ready may stay low indefinitely; the outputs hold and in_ready stays 0.
- After the output handshake, out_valid drops to 0. out_max/out_min/out_count keep their last values until the next packet's first beat overwrites them.
- Throughput: one sample per cycle in FIRST/ACC.

## Test plan
- Reset then packet 3,9,1,7 (last on 7), N=4, out_ready=1 → out_valid one cycle after the 7 beat; max=9, min=1, count=4; in_ready=0 for exactly one cycle.
- Single-beat packet 5 with in_last=1 → max=5, min=5, count=1; then packet 15,0 → max=15, min=0, count=2.
- Ties and bounds: packet 6,6,6 → max=min=6, count=3. Packet 0,15,0,15 → max=15, min=0, count=4.
- Backpressure: hold out_ready=0 for 10 cycles after packet 2,4 → outputs stable at 4/2/2, in_ready=0 throughout, and in_valid beats during DONE are not counted in the next packet.
- Saturation: CW=2, packet of 6 samples 1..6 → count=3, max=6, min=1. Also insert in_valid gaps mid-packet and check that results are unchanged.
- Reset mid-packet after 8,2, then packet 4 (last) → result max=4, min=4, count=1. Also assert rst while out_valid=1 → out_valid=0 and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/minmax_tracker.sv
// Streaming unsigned min/max tracker: folds a packet of samples into running
// extremes and a saturating count, then holds the result on an output handshake.

module minmax_cmp #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         g,
  output logic         l
);

  assign g = (a > b);
  assign l = (a < b);

endmodule

module minmax_tracker #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_max,
  output logic [N-1:0]  out_min,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {FIRST, ACC, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  max_r;
  logic [N-1:0]  min_r;
  logic [CW-1:0] cnt_r;
  logic          accept;
  logic          max_g;
  logic          max_l;
  logic          min_g;
  logic          min_l;
  logic          cmp_unused;

  minmax_cmp #(.N(N)) u_cmp_max (
    .a (in_data),
    .b (max_r),
    .g (max_g),
    .l (max_l)
  );

  minmax_cmp #(.N(N)) u_cmp_min (
    .a (in_data),
    .b (min_r),
    .g (min_g),
    .l (min_l)
  );

  // Only the max instance's g and the min instance's l drive updates.
  assign cmp_unused = max_l ^ min_g;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign out_max   = max_r;
  assign out_min   = min_r;
  assign out_count = cnt_r;

  always_comb begin
    state_nx = state;
    case (state)
      FIRST, ACC: begin
        if (accept) begin
          state_nx = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = FIRST;
        end
      end
      default: state_nx = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIRST;
      max_r <= '0;
      min_r <= '0;
      cnt_r <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (state == FIRST) begin
          max_r <= in_data;
          min_r <= in_data;
          cnt_r <= CW'(1);
        end else begin
          if (max_g) begin
            max_r <= in_data;
          end
          if (min_l) begin
            min_r <= in_data;
          end
          // Count saturates; extremes keep tracking regardless.
          if (cnt_r != {CW{1'b1}}) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed self-checking bench for minmax_tracker; a second instance with CW=2
// shares the same stimulus to exercise count saturation.

module tb_minmax_tracker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [7:0] out_count;
  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [3:0] sat_max;
  logic [3:0] sat_min;
  logic [1:0] sat_count;

  int compared;
  int mismatched;
  logic [3:0] pkt[$];

  minmax_tracker #(.N(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_count (out_count)
  );

  minmax_tracker #(.N(4), .CW(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_max   (sat_max),
    .out_min   (sat_min),
    .out_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends pkt; with gaps set, an idle cycle carrying bait data follows each non-final beat.
  task automatic applyStimulus(input string tag, input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      checkOutput({tag, ".in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      tick();
      in_valid = 1'b0;
      if (gaps && (i != pkt.size() - 1)) begin
        in_data = 4'd15;
        in_last = 1'b1;
        tick();
      end
    end
    in_last = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int mx, input int mn, input int ct);
    checkOutput({tag, ".out_valid"}, int'(out_valid), 1);
    checkOutput({tag, ".in_ready"},  int'(in_ready), 0);
    checkOutput({tag, ".max"},       int'(out_max), mx);
    checkOutput({tag, ".min"},       int'(out_min), mn);
    checkOutput({tag, ".count"},     int'(out_count), ct);
  endtask

  task automatic finishResult(input string tag);
    out_ready = 1'b1;
    tick();
    checkOutput({tag, ".drop_valid"}, int'(out_valid), 0);
    checkOutput({tag, ".ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'd0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset.out_valid", int'(out_valid), 0);
    checkOutput("reset.max",       int'(out_max), 0);
    checkOutput("reset.min",       int'(out_min), 0);
    checkOutput("reset.count",     int'(out_count), 0);
    checkOutput("reset.in_ready",  int'(in_ready), 1);

    $display("[TB] basic packet 3,9,1,7");
    out_ready = 1'b1;
    pkt = '{4'd3, 4'd9, 4'd1, 4'd7};
    applyStimulus("p1", 1'b0);
    checkResult("p1", 9, 1, 4);
    tick();
    checkOutput("p1.drop_valid", int'(out_valid), 0);
    checkOutput("p1.ready_back", int'(in_ready), 1);
    checkOutput("p1.hold_max",   int'(out_max), 9);
    checkOutput("p1.hold_count", int'(out_count), 4);

    $display("[TB] single beat and extremes");
    pkt = '{4'd5};
    applyStimulus("p2", 1'b0);
    checkResult("p2", 5, 5, 1);
    finishResult("p2");
    pkt = '{4'd15, 4'd0};
    applyStimulus("p3", 1'b0);
    checkResult("p3", 15, 0, 2);
    finishResult("p3");

    $display("[TB] ties and bounds");
    pkt = '{4'd6, 4'd6, 4'd6};
    applyStimulus("p4", 1'b0);
    checkResult("p4", 6, 6, 3);
    finishResult("p4");
    pkt = '{4'd0, 4'd15, 4'd0, 4'd15};
    applyStimulus("p5", 1'b0);
    checkResult("p5", 15, 0, 4);
    finishResult("p5");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    pkt = '{4'd2, 4'd4};
    applyStimulus("p6", 1'b0);
    checkResult("p6", 4, 2, 2);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 4'd15;
      in_last  = 1'b1;
      tick();
      checkResult("p6.hold", 4, 2, 2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    finishResult("p6");
    pkt = '{4'd1};
    applyStimulus("p7", 1'b0);
    checkResult("p7", 1, 1, 1);
    finishResult("p7");

    $display("[TB] saturation with and without gaps");
    pkt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    applyStimulus("p8", 1'b0);
    checkResult("p8", 6, 1, 6);
    checkOutput("p8.sat_count", int'(sat_count), 3);
    checkOutput("p8.sat_max",   int'(sat_max), 6);
    checkOutput("p8.sat_min",   int'(sat_min), 1);
    finishResult("p8");
    applyStimulus("p9", 1'b1);
    checkResult("p9", 6, 1, 6);
    checkOutput("p9.sat_count", int'(sat_count), 3);
    checkOutput("p9.sat_max",   int'(sat_max), 6);
    checkOutput("p9.sat_min",   int'(sat_min), 1);
    finishResult("p9");

    $display("[TB] reset mid-packet and during result");
    pkt = '{4'd8, 4'd2};
    in_valid = 1'b1;
    in_data  = 4'd8;
    tick();
    in_data  = 4'd2;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid.out_valid", int'(out_valid), 0);
    checkOutput("rst_mid.in_ready",  int'(in_ready), 1);
    checkOutput("rst_mid.max",       int'(out_max), 0);
    checkOutput("rst_mid.count",     int'(out_count), 0);
    pkt = '{4'd4};
    applyStimulus("p10", 1'b0);
    checkResult("p10", 4, 4, 1);
    finishResult("p10");
    out_ready = 1'b0;
    pkt = '{4'd9, 4'd3};
    applyStimulus("p11", 1'b0);
    checkResult("p11", 9, 3, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_done.out_valid", int'(out_valid), 0);
    checkOutput("rst_done.in_ready",  int'(in_ready), 1);
    checkOutput("rst_done.max",       int'(out_max), 0);
    checkOutput("rst_done.min",       int'(out_min), 0);
    checkOutput("rst_done.count",     int'(out_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
